shift_register_arb_ctrl: RTL and testbench
==========================================

// Module: shift_register_arb_ctrl
// PURPOSE
//   Shares one WIDTH-bit parallel-load / MSB-first shift register among NREQ requesters.
//   Each requester presents a word with a valid/ready handshake; a round-robin arbiter grants one,
//   the word is loaded and shifted out serially at a programmable bit rate, then the next grant follows.
//   Sits between packet-side producers and a single serial output line (link/LED/config chain).
// PARAMETERS
//   WIDTH   8   bits per word; WIDTH >= 2
//   NREQ    2   number of requesters; 2..8
//   DIV_W   8   width of bit-period divider input
// PORTS
//   clk          in   1            clock; all state on posedge
//   reset_n      in   1            asynchronous active-low reset
//   req_valid_i  in   NREQ         requester i has a word to send
//   req_data_i   in   NREQ*WIDTH   word of requester i at [i*WIDTH +: WIDTH]
//   req_ready_o  out  NREQ         one-hot accept; handshake when valid & ready
//   div_i        in   DIV_W        bit period minus one, in clk cycles
//   ser_o        out  1            serial data, MSB first
//   ser_valid_o  out  1            high while ser_o carries a word bit
//   ser_bit_o    out  1            1-cycle strobe on first cycle of each bit period
//   ser_last_o   out  1            high during the whole final bit period
//   grant_id_o   out  $clog2(NREQ) index of requester owning current transfer
//   busy_o       out  1            high in SHIFT
//   done_o       out  1            1-cycle pulse the cycle after final bit period ends
// BEHAVIOUR
// - Reset (async assert, sync-safe release): state=IDLE, shift reg, bit/div counters, all outputs 0;
//   rr pointer = 0 so requester 0 has highest priority at first arbitration.
// - FSM: IDLE, SHIFT.
// - IDLE: if any req_valid_i, pick first valid index searching from rr_ptr upward, wrapping modulo NREQ.
//   req_ready_o[g]=1 combinationally in that same cycle (only in IDLE; never more than one bit set).
//   On handshake: load req_data_i[g], latch div_i into div_q, grant_id_o<=g, rr_ptr<=(g+1)%NREQ,
//   bit_cnt<=WIDTH-1, div_cnt<=div_i, state<=SHIFT. No valid: stay IDLE, nothing changes.
// - SHIFT: ser_o = shreg[WIDTH-1]; ser_valid_o=busy_o=1. ser_bit_o=1 when div_cnt==div_q.
//   div_cnt decrements each cycle; at 0: if bit_cnt==0 -> state<=IDLE, done_o<=1;
//   else shreg<<=1 (zero fill), bit_cnt--, div_cnt<=div_q. ser_last_o = (bit_cnt==0).
// - Latency: handshake at cycle N -> first bit on ser_o at N+1; word occupies WIDTH*(div_q+1)
//   cycles; done_o at N+1+WIDTH*(div_q+1), which is an IDLE cycle where a new grant may
//   handshake (back-to-back, no gap cycle).
// - div_i changes during SHIFT are ignored (div_q sampled at load only). div_i=0 -> 1 cycle/bit.
// - req_valid_i / req_data_i changes during SHIFT have no effect; requester must hold valid
//   until its ready; dropping valid before grant is legal (request withdrawn).
// - In IDLE ser_o, ser_valid_o, ser_bit_o, ser_last_o are 0; grant_id_o keeps last value.
// - Reset mid-SHIFT: transfer aborted, no done_o, outputs 0 immediately (async).
// - Fairness: a continuously valid requester waits at most NREQ-1 transfers.
// TESTING
// 1. WIDTH=8, div_i=0, only req0 valid, data 0xA5 at cycle N -> ready0 at N; ser_o=1,0,1,0,0,1,0,1
//    at N+1..N+8; ser_bit_o every cycle; ser_last_o at N+8; done_o at N+9.
// 2. div_i=2, data 0x81 -> each bit held 3 cycles, ser_bit_o on first of each; 24 SHIFT cycles;
//    done_o 25 cycles after handshake; change div_i to 0 mid-word -> timing unchanged.
// 3. NREQ=2, both valid continuously from reset, data0=0x11 data1=0x22 -> grants 0,1,0,1;
//    grant_id_o matches; done_o cycle of each word coincides with next handshake (no gap).
// 4. req1 asserts valid during req0 SHIFT -> req_ready_o stays 0 until done_o cycle, then ready1=1.
// 5. Assert reset_n=0 at bit 3 of a word -> ser_valid_o/ser_o/busy_o drop same cycle, no done_o;
//    after release with req1 and req0 valid -> req0 granted first (rr_ptr reset to 0).
// 6. NREQ=4, only req3 and req1 valid, rr_ptr=2 -> req3 granted, then req1; never two ready bits.

Source files
------------

// File: rtl/shift_register_arb_ctrl.sv
// Round-robin arbiter feeding one shared parallel-load, MSB-first serial shift register.
// Each granted word is shifted out at a bit period of (div_i + 1) clock cycles, sampled at load.
module shift_register_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2,
    parameter int DIV_W = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*WIDTH-1:0]     req_data_i,
    output logic [NREQ-1:0]           req_ready_o,
    input  logic [DIV_W-1:0]          div_i,
    output logic                      ser_o,
    output logic                      ser_valid_o,
    output logic                      ser_bit_o,
    output logic                      ser_last_o,
    output logic [$clog2(NREQ)-1:0]   grant_id_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      dbg_state_o
);

    localparam int GW = $clog2(NREQ);
    localparam int BW = $clog2(WIDTH);
    localparam logic [GW:0]   NREQ_W   = (GW+1)'(NREQ);
    localparam logic [GW-1:0] LAST_REQ = GW'(NREQ - 1);

    // Handshake: a word moves when req_valid_i[g] & req_ready_o[g] at a rising edge.
    // Ready is only offered in IDLE, to at most one requester, and never depends on ready.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shreg;
    logic [BW-1:0]     bit_cnt;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [GW-1:0]     rr_ptr;

    logic              gnt_found;
    logic [GW-1:0]     gnt_idx;
    logic [GW:0]       arb_sum;
    logic [WIDTH-1:0]  load_data;
    logic              handshake;
    logic              word_end;

    // Search from rr_ptr upward, wrapping, for the first valid requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        arb_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            arb_sum = {1'b0, rr_ptr} + (GW+1)'(k);
            if (arb_sum >= NREQ_W) begin
                arb_sum = arb_sum - NREQ_W;
            end
            if (!gnt_found && req_valid_i[arb_sum[GW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = arb_sum[GW-1:0];
            end
        end
    end

    always_comb begin
        load_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (GW'(k) == gnt_idx) begin
                load_data = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state_q == IDLE && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    assign handshake = (state_q == IDLE) && gnt_found;
    assign word_end  = (state_q == SHIFT) && (div_cnt == '0) && (bit_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (handshake) state_d = SHIFT;
            SHIFT:   if (word_end)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            div_q      <= '0;
            rr_ptr     <= '0;
            grant_id_o <= '0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (state_q == IDLE) begin
                if (handshake) begin
                    shreg      <= load_data;
                    div_q      <= div_i;
                    div_cnt    <= div_i;
                    bit_cnt    <= BW'(WIDTH - 1);
                    grant_id_o <= gnt_idx;
                    rr_ptr     <= (gnt_idx == LAST_REQ) ? '0 : gnt_idx + GW'(1);
                end
            end else if (div_cnt == '0) begin
                if (bit_cnt == '0) begin
                    done_o <= 1'b1;
                end else begin
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt - BW'(1);
                    div_cnt <= div_q;
                end
            end else begin
                div_cnt <= div_cnt - DIV_W'(1);
            end
        end
    end

    // Serial outputs are gated by state so an async reset silences them at once.
    assign busy_o      = (state_q == SHIFT);
    assign ser_valid_o = busy_o;
    assign ser_o       = busy_o && shreg[WIDTH-1];
    assign ser_bit_o   = busy_o && (div_cnt == div_q);
    assign ser_last_o  = busy_o && (bit_cnt == '0);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shift_register_arb_ctrl.sv
// Directed bench for shift_register_arb_ctrl (NREQ=4): stimulus pushes expected words,
// a negedge monitor reassembles serial words and compares on every done_o.
module tb_shift_register_arb_ctrl;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int DIV_W = 8;
    localparam int GW    = 2;

    logic                  clk;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic [DIV_W-1:0]      div_i;
    logic                  ser_o, ser_valid_o, ser_bit_o, ser_last_o;
    logic [GW-1:0]         grant_id_o;
    logic                  busy_o, done_o, dbg_state_o;

    int vectors;
    int miscompares;

    // Expected word record: {gid[39:32], data[31:24], shift cycles[23:8], last-bit cycles[7:0]}
    logic [39:0] exp_q[$];

    shift_register_arb_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .DIV_W(DIV_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .div_i       (div_i),
        .ser_o       (ser_o),
        .ser_valid_o (ser_valid_o),
        .ser_bit_o   (ser_bit_o),
        .ser_last_o  (ser_last_o),
        .grant_id_o  (grant_id_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .dbg_state_o (dbg_state_o)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [7:0] gid, input logic [7:0] data,
                            input logic [15:0] ncyc, input logic [7:0] nlast);
        exp_q.push_back({gid, data, ncyc, nlast});
    endtask

    // Driver: offer one word from requester idx from a fresh cycle; checks the offered ready.
    task automatic send(input int idx, input logic [7:0] data, input logic [7:0] div,
                        input logic [NREQ-1:0] exp_ready);
        @(posedge clk); #1;
        req_data[idx*WIDTH +: WIDTH] = data;
        div_i = div;
        req_valid[idx] = 1'b1;
        @(negedge clk);
        check("ready_offer", 32'(req_ready), 32'(exp_ready));
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    // Counts negedges from the handshake until done_o; optionally checks ready stays low meanwhile.
    task automatic wait_done(input int start, input int exp_lat, input bit chk_no_ready);
        int n;
        bit got;
        n = start;
        got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            if (done_o) got = 1'b1;
            else if (chk_no_ready) check("ready_during_shift", 32'(req_ready), 32'h0);
        end
        if (!got) $display("FAIL done_timeout: no done_o after %0d cycles", n);
        check("done_latency", n, exp_lat);
    endtask

    // Monitor / scoreboard
    logic [7:0] acc;
    int nbits, ncyc, nlast;
    logic [39:0] e;

    always @(negedge clk) begin
        if (!reset_n) begin
            acc = '0; nbits = 0; ncyc = 0; nlast = 0;
        end else begin
            check("ready_onehot0", 32'($onehot0(req_ready)), 32'h1);
            check("valid_vs_state", 32'(ser_valid_o), 32'(dbg_state_o));
            if (busy_o) begin
                ncyc++;
                if (ser_last_o) nlast++;
                if (ser_bit_o) begin
                    acc = {acc[6:0], ser_o};
                    nbits++;
                end
            end else begin
                check("idle_ser_outputs", 32'({ser_o, ser_bit_o, ser_last_o}), 32'h0);
            end
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_done: got word 0x%0h expected none", acc);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data",   32'(acc),        32'(e[31:24]));
                    check("word_grant",  32'(grant_id_o), 32'(e[39:32]));
                    check("word_cycles", ncyc,            32'(e[23:8]));
                    check("last_cycles", nlast,           32'(e[7:0]));
                    check("bit_strobes", nbits,           WIDTH);
                end
                acc = '0; nbits = 0; ncyc = 0; nlast = 0;
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        reset_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        div_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy",  32'(busy_o), 32'h0);
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_done",  32'(done_o), 32'h0);
        check("reset_grant", 32'(grant_id_o), 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Single requester, one cycle per bit
        push_exp(0, 8'hA5, 8, 1);
        send(0, 8'hA5, 8'd0, 4'b0001);
        wait_done(0, 9, 1'b0);

        // Three cycles per bit; divider input change mid-word must not matter
        push_exp(0, 8'h81, 24, 3);
        send(0, 8'h81, 8'd2, 4'b0001);
        repeat (4) @(negedge clk);
        div_i = 8'd0;
        wait_done(4, 25, 1'b0);

        // Request arriving during a transfer waits for the done cycle
        push_exp(0, 8'h3C, 8, 1);
        push_exp(1, 8'h5A, 8, 1);
        send(0, 8'h3C, 8'd0, 4'b0001);
        req_data[1*WIDTH +: WIDTH] = 8'h5A;
        req_valid[1] = 1'b1;
        wait_done(0, 9, 1'b1);
        check("ready_at_done", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        wait_done(0, 9, 1'b0);

        // rr_ptr now 2: req3 wins over req1, then req1
        push_exp(3, 8'hC3, 16, 2);
        push_exp(1, 8'h96, 16, 2);
        @(posedge clk); #1;
        req_data[3*WIDTH +: WIDTH] = 8'hC3;
        req_data[1*WIDTH +: WIDTH] = 8'h96;
        div_i = 8'd1;
        req_valid = 4'b1010;
        @(negedge clk);
        check("ready_rr_wrap", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_done(0, 17, 1'b1);
        check("ready_next_rr", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done(0, 17, 1'b0);

        // Abort at bit 3 with an async reset
        send(0, 8'hF0, 8'd0, 4'b0001);
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy_o), 32'h1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy",      32'(busy_o), 32'h0);
        check("abort_ser_valid", 32'(ser_valid_o), 32'h0);
        check("abort_ser",       32'(ser_o), 32'h0);
        req_data[0*WIDTH +: WIDTH] = 8'h11;
        req_data[1*WIDTH +: WIDTH] = 8'h22;
        div_i = 8'd0;
        req_valid = 4'b0011;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(done_o), 32'h0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Both valid continuously: 0,1,0,1 with no gap cycles
        push_exp(0, 8'h11, 8, 1);
        push_exp(1, 8'h22, 8, 1);
        push_exp(0, 8'h11, 8, 1);
        push_exp(1, 8'h22, 8, 1);
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        wait_done(0, 9, 1'b0);
        check("b2b_ready_1", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        wait_done(0, 9, 1'b0);
        check("b2b_ready_2", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        wait_done(0, 9, 1'b0);
        check("b2b_ready_3", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        wait_done(0, 9, 1'b0);
        check("final_ready", 32'(req_ready), 32'h0);

        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
